ads1274_responder: RTL and testbench

ADS1274_RESPONDER -- requirements
Module: ads1274_responder

---
 rtl/ads1274_responder_if.sv | 25 ++
 rtl/ads1274_responder.sv | 178 +++++++++++++++++
 tb/tb_ads1274_responder.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ads1274_responder_if.sv
// Host-side and loader-side signal bundle for the ADS1274 responder.
// The master modport is the host/loader; the slave modport is the responder.
interface ads1274_responder_if #(
  parameter int FRAME_BITS = 96
) ();
  logic                  aClk;
  logic                  SClk;
  logic                  nSync;
  logic                  Load;
  logic [FRAME_BITS-1:0] DataIn;
  logic                  nDRdy;
  logic                  Data;
  logic                  Overrun;
  logic                  Underrun;

  modport master (
    output aClk, SClk, nSync, Load, DataIn,
    input  nDRdy, Data, Overrun, Underrun
  );

  modport slave (
    input  aClk, SClk, nSync, Load, DataIn,
    output nDRdy, Data, Overrun, Underrun
  );
endinterface

// File: rtl/ads1274_responder.sv
// ADS1274 responder: emulates the frame-mode serial output of a 4-channel
// 24-bit ADC. A frame is produced every CLKS_PER_SAMPLE aClk rising edges;
// the host clocks it out on SClk falling edges, MSB of channel 1 first.
module ads1274_responder #(
  parameter int CLKS_PER_SAMPLE = 256,
  parameter int FRAME_BITS      = 96
) (
  input  logic                  Clk,
  input  logic                  nReset,
  ads1274_responder_if.slave    bus
);

  localparam int CH_W  = FRAME_BITS / 4;
  localparam int CNT_W = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;
  localparam int BIT_W = $clog2(FRAME_BITS);

  localparam logic [CNT_W-1:0] SMP_LAST = CNT_W'(CLKS_PER_SAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

  // WAIT: idle, Data=0. REARM: one Clk with nDRdy high after a frame was
  // replaced mid-read, so the host sees a fresh falling edge. READY: first
  // bit presented, nDRdy low. SHIFT: bits advancing on SClk falling edges.
  typedef enum logic [1:0] {
    ST_WAIT,
    ST_REARM,
    ST_READY,
    ST_SHIFT
  } state_t;

  // Reorder the channel-packed sample so the shift register MSB is ch1 bit 23
  // and ch4 bit 0 leaves last.
  function automatic logic [FRAME_BITS-1:0] frame_order(input logic [FRAME_BITS-1:0] d);
    logic [FRAME_BITS-1:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      r[FRAME_BITS-1-c*CH_W -: CH_W] = d[c*CH_W +: CH_W];
    end
    return r;
  endfunction

  // Synchronizer stages: _p0/_p1 form the 2-flop synchronizer, _p2 is the
  // previous synchronized value used for edge detection.
  logic aclk_p0, aclk_p1, aclk_p2;
  logic sclk_p0, sclk_p1, sclk_p2;
  logic nsync_p0, nsync_p1;

  logic [CNT_W-1:0]      smp_cnt;
  logic [BIT_W-1:0]      bit_cnt, bit_cnt_nxt;
  logic [FRAME_BITS-1:0] sh_reg, sh_reg_nxt;
  logic [FRAME_BITS-1:0] pend_reg, pend_reg_nxt;
  logic                  pend_vld, pend_vld_nxt;
  logic                  overrun_q, overrun_nxt;
  logic                  underrun_q, underrun_nxt;
  state_t                state, state_nxt;

  logic aclk_rise;
  logic sclk_fall;
  logic sync_n;
  logic frame_tick;

  // Bring the three host pins into the Clk domain and keep a delayed copy
  // of aClk/SClk for edge detection.
  always_ff @(posedge Clk) begin
    if (!nReset) begin
      aclk_p0  <= 1'b0;
      aclk_p1  <= 1'b0;
      aclk_p2  <= 1'b0;
      sclk_p0  <= 1'b0;
      sclk_p1  <= 1'b0;
      sclk_p2  <= 1'b0;
      nsync_p0 <= 1'b0;
      nsync_p1 <= 1'b0;
    end else begin
      aclk_p0  <= bus.aClk;
      aclk_p1  <= aclk_p0;
      aclk_p2  <= aclk_p1;
      sclk_p0  <= bus.SClk;
      sclk_p1  <= sclk_p0;
      sclk_p2  <= sclk_p1;
      nsync_p0 <= bus.nSync;
      nsync_p1 <= nsync_p0;
    end
  end

  assign aclk_rise  = aclk_p1 & ~aclk_p2;
  assign sclk_fall  = sclk_p2 & ~sclk_p1;
  assign sync_n     = nsync_p1;
  assign frame_tick = sync_n & aclk_rise & (smp_cnt == SMP_LAST);

  // Sample counter: counts synchronized aClk rising edges, held at 0 while
  // nSync is asserted so counting restarts cleanly on release.
  always_ff @(posedge Clk) begin
    if (!nReset) begin
      smp_cnt <= '0;
    end else if (!sync_n) begin
      smp_cnt <= '0;
    end else if (aclk_rise) begin
      smp_cnt <= (smp_cnt == SMP_LAST) ? '0 : smp_cnt + 1'b1;
    end
  end

  // Frame state, shift/pending registers and status pulses.
  always_ff @(posedge Clk) begin
    if (!nReset) begin
      state      <= ST_WAIT;
      bit_cnt    <= '0;
      sh_reg     <= '0;
      pend_reg   <= '0;
      pend_vld   <= 1'b0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      bit_cnt    <= bit_cnt_nxt;
      sh_reg     <= sh_reg_nxt;
      pend_reg   <= pend_reg_nxt;
      pend_vld   <= pend_vld_nxt;
      overrun_q  <= overrun_nxt;
      underrun_q <= underrun_nxt;
    end
  end

  // Next-state logic: a frame tick preempts everything except nSync; a Load
  // on the tick cycle feeds its DataIn straight into the new frame.
  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    sh_reg_nxt   = sh_reg;
    pend_reg_nxt = pend_reg;
    pend_vld_nxt = pend_vld;
    overrun_nxt  = 1'b0;
    underrun_nxt = 1'b0;

    if (bus.Load) begin
      pend_reg_nxt = bus.DataIn;
      pend_vld_nxt = 1'b1;
    end

    if (!sync_n) begin
      state_nxt = ST_WAIT;
    end else if (frame_tick) begin
      sh_reg_nxt   = frame_order(bus.Load ? bus.DataIn : pend_reg);
      bit_cnt_nxt  = BIT_LAST;
      pend_vld_nxt = 1'b0;
      overrun_nxt  = (state != ST_WAIT);
      underrun_nxt = ~pend_vld & ~bus.Load;
      state_nxt    = (state == ST_WAIT) ? ST_READY : ST_REARM;
    end else begin
      case (state)
        ST_REARM: state_nxt = ST_READY;
        ST_READY: begin
          if (sclk_fall) begin
            sh_reg_nxt  = {sh_reg[FRAME_BITS-2:0], 1'b0};
            bit_cnt_nxt = bit_cnt - 1'b1;
            state_nxt   = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (sclk_fall) begin
            if (bit_cnt == '0) begin
              state_nxt = ST_WAIT;
            end else begin
              sh_reg_nxt  = {sh_reg[FRAME_BITS-2:0], 1'b0};
              bit_cnt_nxt = bit_cnt - 1'b1;
            end
          end
        end
        default: state_nxt = state;
      endcase
    end
  end

  assign bus.nDRdy    = (state != ST_READY);
  assign bus.Data     = (state == ST_WAIT) ? 1'b0 : sh_reg[FRAME_BITS-1];
  assign bus.Overrun  = overrun_q;
  assign bus.Underrun = underrun_q;

endmodule

// File: tb/tb_ads1274_responder.sv
// Testbench for ads1274_responder with a short frame period.
module tb_ads1274_responder;

  localparam int CPS = 8;

  logic Clk = 1'b0;
  logic nReset;

  always #5 Clk = ~Clk;

  ads1274_responder_if #(.FRAME_BITS(96)) bus ();

  ads1274_responder #(
    .CLKS_PER_SAMPLE(CPS),
    .FRAME_BITS(96)
  ) dut (
    .Clk(Clk),
    .nReset(nReset),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int ovr_cnt = 0;
  int und_cnt = 0;
  int rdy_low_cnt = 0;
  logic [23:0] exp_q[$];

  // Pulse and ready-level counters sampled mid-cycle.
  always @(negedge Clk) begin
    if (bus.Overrun === 1'b1) ovr_cnt++;
    if (bus.Underrun === 1'b1) und_cnt++;
    if (bus.nDRdy === 1'b0) rdy_low_cnt++;
  end

  task automatic push_frame(input logic [95:0] d);
    exp_q.push_back(d[23:0]);
    exp_q.push_back(d[47:24]);
    exp_q.push_back(d[71:48]);
    exp_q.push_back(d[95:72]);
  endtask

  task automatic pop_word(output logic [23:0] w);
    if (exp_q.size() > 0) w = exp_q.pop_front();
    else w = 'x;
  endtask

  task automatic load(input logic [95:0] d);
    @(negedge Clk);
    bus.Load = 1'b1;
    bus.DataIn = d;
    @(negedge Clk);
    bus.Load = 1'b0;
  endtask

  task automatic aclk_edges(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      bus.aClk = 1'b1;
      repeat (3) @(negedge Clk);
      bus.aClk = 1'b0;
      repeat (3) @(negedge Clk);
    end
  endtask

  task automatic sclk_pulse(output logic b);
    @(negedge Clk);
    bus.SClk = 1'b1;
    repeat (2) @(negedge Clk);
    b = bus.Data;
    bus.SClk = 1'b0;
    repeat (4) @(negedge Clk);
  endtask

  task automatic read_bits(input int n, output logic [95:0] got);
    logic b;
    got = '0;
    for (int i = 0; i < n; i++) begin
      sclk_pulse(b);
      got = {got[94:0], b};
    end
  endtask

  task automatic wait_ready(output bit ok);
    int n;
    ok = 0;
    n = 0;
    while (!ok && n < 30) begin
      @(negedge Clk);
      n++;
      if (bus.nDRdy === 1'b0) ok = 1;
    end
  endtask

  task automatic test_reset();
    nReset = 1'b0;
    repeat (3) @(negedge Clk);
    checks++; if (bus.nDRdy !== 1'b1) begin errors++; $display("FAIL reset_ndrdy: got %b expected 1", bus.nDRdy); end
    checks++; if (bus.Data !== 1'b0) begin errors++; $display("FAIL reset_data: got %b expected 0", bus.Data); end
    checks++; if (bus.Overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", bus.Overrun); end
    checks++; if (bus.Underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b expected 0", bus.Underrun); end
    nReset = 1'b1;
    repeat (5) @(negedge Clk);
  endtask

  task automatic test_basic();
    logic [95:0] d = 96'h444444_333333_222222_111111;
    logic [95:0] got;
    logic [95:0] rest;
    logic [23:0] w;
    logic b;
    bit ok;
    int o0, u0;
    o0 = ovr_cnt; u0 = und_cnt;
    load(d);
    push_frame(d);
    aclk_edges(CPS - 1);
    checks++; if (bus.nDRdy !== 1'b1) begin errors++; $display("FAIL basic_early_ready: got %b expected 1", bus.nDRdy); end
    aclk_edges(1);
    wait_ready(ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_ready_timeout: got no nDRdy low expected low"); end
    sclk_pulse(b);
    checks++; if (bus.nDRdy !== 1'b1) begin errors++; $display("FAIL basic_ndrdy_after_fall: got %b expected 1", bus.nDRdy); end
    read_bits(95, rest);
    got = {b, rest[94:0]};
    for (int i = 0; i < 4; i++) begin
      pop_word(w);
      checks++;
      if (got[95-24*i -: 24] !== w) begin errors++; $display("FAIL basic_word%0d: got %h expected %h", i, got[95-24*i -: 24], w); end
    end
    sclk_pulse(b);
    checks++; if (b !== 1'b0 || bus.Data !== 1'b0) begin errors++; $display("FAIL basic_wait_data: got %b/%b expected 0/0", b, bus.Data); end
    checks++; if (ovr_cnt != o0 || und_cnt != u0) begin errors++; $display("FAIL basic_flags: got ovr %0d und %0d expected 0 0", ovr_cnt - o0, und_cnt - u0); end
  endtask

  task automatic test_overrun();
    logic [95:0] bv = 96'h89ABCD_012345_FEDCBA_765432;
    logic [95:0] cv = 96'h5A5A5A_C3C3C3_0F0F0F_955555;
    logic [95:0] got;
    logic [23:0] w;
    bit ok, found;
    int n, o0, u0;
    load(bv);
    push_frame(bv);
    aclk_edges(CPS);
    wait_ready(ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovr_ready_timeout: got no nDRdy low expected low"); end
    read_bits(40, got);
    pop_word(w);
    checks++; if (got[39:16] !== w) begin errors++; $display("FAIL ovr_partial_w0: got %h expected %h", got[39:16], w); end
    pop_word(w);
    checks++; if (got[15:0] !== w[23:8]) begin errors++; $display("FAIL ovr_partial_w1: got %h expected %h", got[15:0], w[23:8]); end
    pop_word(w);
    pop_word(w);
    load(cv);
    push_frame(cv);
    o0 = ovr_cnt; u0 = und_cnt;
    aclk_edges(CPS - 1);
    @(negedge Clk);
    bus.aClk = 1'b1;
    found = 0; n = 0;
    while (!found && n < 10) begin
      @(negedge Clk);
      n++;
      if (bus.Overrun === 1'b1) found = 1;
    end
    checks++; if (!found) begin errors++; $display("FAIL ovr_pulse: got none expected Overrun pulse"); end
    if (found) begin
      checks++; if (bus.nDRdy !== 1'b1) begin errors++; $display("FAIL ovr_ndrdy_high: got %b expected 1", bus.nDRdy); end
      @(negedge Clk);
      checks++; if (bus.nDRdy !== 1'b0) begin errors++; $display("FAIL ovr_ndrdy_low: got %b expected 0", bus.nDRdy); end
      checks++; if (bus.Overrun !== 1'b0) begin errors++; $display("FAIL ovr_pulse_width: got %b expected 0", bus.Overrun); end
      checks++; if (bus.Data !== cv[23]) begin errors++; $display("FAIL ovr_first_bit: got %b expected %b", bus.Data, cv[23]); end
    end
    repeat (2) @(negedge Clk);
    bus.aClk = 1'b0;
    repeat (3) @(negedge Clk);
    checks++; if (ovr_cnt - o0 != 1 || und_cnt != u0) begin errors++; $display("FAIL ovr_counts: got ovr %0d und %0d expected 1 0", ovr_cnt - o0, und_cnt - u0); end
    read_bits(96, got);
    for (int i = 0; i < 4; i++) begin
      pop_word(w);
      checks++;
      if (got[95-24*i -: 24] !== w) begin errors++; $display("FAIL ovr_new_word%0d: got %h expected %h", i, got[95-24*i -: 24], w); end
    end
  endtask

  task automatic test_underrun();
    logic [95:0] d = 96'h000000_000000_000000_800001;
    logic [95:0] got;
    logic [23:0] w;
    bit ok;
    int u0, o0;
    load(d);
    push_frame(d);
    for (int f = 0; f < 2; f++) begin
      u0 = und_cnt; o0 = ovr_cnt;
      if (f == 1) push_frame(d);
      aclk_edges(CPS);
      wait_ready(ok);
      checks++; if (!ok) begin errors++; $display("FAIL und_ready_timeout%0d: got no nDRdy low expected low", f); end
      checks++; if (und_cnt - u0 != f || ovr_cnt != o0) begin errors++; $display("FAIL und_count%0d: got und %0d ovr %0d expected %0d 0", f, und_cnt - u0, ovr_cnt - o0, f); end
      read_bits(96, got);
      for (int i = 0; i < 4; i++) begin
        pop_word(w);
        checks++;
        if (got[95-24*i -: 24] !== w) begin errors++; $display("FAIL und_frame%0d_word%0d: got %h expected %h", f, i, got[95-24*i -: 24], w); end
      end
    end
  endtask

  task automatic test_nsync();
    logic [95:0] d = 96'h7FFFFF_800000_000001_FFFFFE;
    logic [95:0] got;
    logic [23:0] w;
    bit ok;
    int r0;
    load(d);
    push_frame(d);
    @(negedge Clk);
    bus.nSync = 1'b0;
    repeat (4) @(negedge Clk);
    r0 = rdy_low_cnt;
    aclk_edges(20);
    checks++; if (rdy_low_cnt != r0 || bus.Data !== 1'b0) begin errors++; $display("FAIL nsync_hold: got %0d ready cycles data %b expected 0 0", rdy_low_cnt - r0, bus.Data); end
    bus.nSync = 1'b1;
    repeat (5) @(negedge Clk);
    aclk_edges(CPS - 1);
    checks++; if (rdy_low_cnt != r0) begin errors++; $display("FAIL nsync_early: got %0d ready cycles expected 0", rdy_low_cnt - r0); end
    aclk_edges(1);
    wait_ready(ok);
    checks++; if (!ok) begin errors++; $display("FAIL nsync_ready_timeout: got no nDRdy low expected low"); end
    read_bits(96, got);
    for (int i = 0; i < 4; i++) begin
      pop_word(w);
      checks++;
      if (got[95-24*i -: 24] !== w) begin errors++; $display("FAIL nsync_word%0d: got %h expected %h", i, got[95-24*i -: 24], w); end
    end
  endtask

  task automatic test_reset_mid();
    logic [95:0] x = 96'h00000F_0000F0_000F00_00F000;
    logic [95:0] y = 96'h123456_789ABC_DEF012_345678;
    logic [95:0] got;
    logic [23:0] w;
    logic b;
    bit ok;
    int r0, u0;
    load(x);
    aclk_edges(CPS);
    wait_ready(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_ready_timeout: got no nDRdy low expected low"); end
    read_bits(50, got);
    @(negedge Clk);
    nReset = 1'b0;
    @(negedge Clk);
    checks++; if (bus.nDRdy !== 1'b1 || bus.Data !== 1'b0 || bus.Overrun !== 1'b0 || bus.Underrun !== 1'b0) begin
      errors++; $display("FAIL rst_mid_outputs: got %b%b%b%b expected 1000", bus.nDRdy, bus.Data, bus.Overrun, bus.Underrun);
    end
    repeat (2) @(negedge Clk);
    nReset = 1'b1;
    repeat (5) @(negedge Clk);
    for (int i = 0; i < 5; i++) begin
      sclk_pulse(b);
      checks++; if (b !== 1'b0 || bus.Data !== 1'b0) begin errors++; $display("FAIL rst_sclk_data%0d: got %b/%b expected 0/0", i, b, bus.Data); end
    end
    load(y);
    push_frame(y);
    r0 = rdy_low_cnt; u0 = und_cnt;
    aclk_edges(CPS - 1);
    checks++; if (rdy_low_cnt != r0) begin errors++; $display("FAIL rst_early_tick: got %0d ready cycles expected 0", rdy_low_cnt - r0); end
    aclk_edges(1);
    wait_ready(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_tick_timeout: got no nDRdy low expected low"); end
    checks++; if (und_cnt != u0) begin errors++; $display("FAIL rst_underrun: got %0d expected 0", und_cnt - u0); end
    read_bits(96, got);
    for (int i = 0; i < 4; i++) begin
      pop_word(w);
      checks++;
      if (got[95-24*i -: 24] !== w) begin errors++; $display("FAIL rst_word%0d: got %h expected %h", i, got[95-24*i -: 24], w); end
    end
  endtask

  task automatic test_load_on_tick();
    logic [95:0] z = 96'hFFFFFF_000000_FFFFFF_000000;
    logic [95:0] got;
    logic [23:0] w;
    bit ok;
    int u0;
    u0 = und_cnt;
    push_frame(z);
    aclk_edges(CPS - 1);
    @(negedge Clk);
    bus.aClk = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    bus.Load = 1'b1;
    bus.DataIn = z;
    @(negedge Clk);
    bus.Load = 1'b0;
    bus.DataIn = '0;
    @(negedge Clk);
    bus.aClk = 1'b0;
    repeat (3) @(negedge Clk);
    wait_ready(ok);
    checks++; if (!ok) begin errors++; $display("FAIL lot_ready_timeout: got no nDRdy low expected low"); end
    checks++; if (und_cnt != u0) begin errors++; $display("FAIL lot_underrun: got %0d expected 0", und_cnt - u0); end
    read_bits(96, got);
    for (int i = 0; i < 4; i++) begin
      pop_word(w);
      checks++;
      if (got[95-24*i -: 24] !== w) begin errors++; $display("FAIL lot_word%0d: got %h expected %h", i, got[95-24*i -: 24], w); end
    end
  endtask

  initial begin
    nReset     = 1'b0;
    bus.aClk   = 1'b0;
    bus.SClk   = 1'b0;
    bus.nSync  = 1'b1;
    bus.Load   = 1'b0;
    bus.DataIn = '0;
    test_reset();
    test_basic();
    test_overrun();
    test_underrun();
    test_nsync();
    test_reset_mid();
    test_load_on_tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
